// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7N2 serial receiver: FSM state codes and frame geometry.
package rx_serial_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'd0,
      CONFIRMA    = 4'd1,
      RECEBE      = 4'd2,
      ARMAZENA    = 4'd3,
      FINAL       = 4'd4,
      ESPERA_IDLE = 4'd5
   } estado_t;

   localparam int N_DADOS            = 7;
   localparam int N_STOP             = 2;
   localparam int N_AMOSTRAS         = N_DADOS + N_STOP;
   localparam int CLOCKS_POR_BIT_DEF = 5208;

endpackage

// File: rtl/rx_serial_7n2_uc.sv
// Control FSM of the 7N2 receiver: sequences start confirmation, bit sampling,
// character load and the completion pulse.
module rx_serial_7n2_uc
   import rx_serial_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_s_i,
   input  logic       fim_meio_i,
   input  logic       fim_bit_i,
   input  logic       ultimo_i,
   output logic       zera_o,
   output logic       conta_o,
   output logic       desloca_o,
   output logic       carrega_o,
   output logic       tick_o,
   output logic       pronto_o,
   output logic [3:0] db_estado_o
);

   estado_t estado_q, estado_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) estado_q <= INICIAL;
      else        estado_q <= estado_d;
   end

   always_comb begin
      estado_d  = estado_q;
      zera_o    = 1'b0;
      conta_o   = 1'b0;
      desloca_o = 1'b0;
      carrega_o = 1'b0;
      tick_o    = 1'b0;
      pronto_o  = 1'b0;
      case (estado_q)
         INICIAL: begin
            if (!rx_s_i) begin
               zera_o   = 1'b1;
               estado_d = CONFIRMA;
            end
         end
         // A line that is high again at mid-start was only a glitch.
         CONFIRMA: begin
            if (fim_meio_i) begin
               tick_o   = 1'b1;
               zera_o   = 1'b1;
               estado_d = rx_s_i ? INICIAL : RECEBE;
            end else begin
               conta_o = 1'b1;
            end
         end
         RECEBE: begin
            if (fim_bit_i) begin
               tick_o    = 1'b1;
               desloca_o = 1'b1;
               if (ultimo_i) estado_d = ARMAZENA;
            end else begin
               conta_o = 1'b1;
            end
         end
         ARMAZENA: begin
            carrega_o = 1'b1;
            estado_d  = FINAL;
         end
         FINAL: begin
            pronto_o = 1'b1;
            estado_d = rx_s_i ? INICIAL : ESPERA_IDLE;
         end
         ESPERA_IDLE: begin
            if (rx_s_i) estado_d = INICIAL;
         end
         default: estado_d = INICIAL;
      endcase
   end

   assign db_estado_o = estado_q;

endmodule

// File: rtl/rx_serial_7n2.sv
// 7N2 asynchronous serial receiver: synchronizer, bit timer, sample counter and
// shift register, sequenced by rx_serial_7n2_uc.
module rx_serial_7n2
   import rx_serial_pkg::*;
#(
   parameter int CLOCKS_POR_BIT = CLOCKS_POR_BIT_DEF
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       dado_serial,
   output logic [6:0] dados_ascii,
   output logic       pronto,
   output logic       erro_stop,
   output logic       db_clock,
   output logic       db_tick,
   output logic       db_dado_serial,
   output logic [3:0] db_estado
);

   localparam int HALF_BIT = CLOCKS_POR_BIT / 2;
   localparam int TW       = (CLOCKS_POR_BIT > 1) ? $clog2(CLOCKS_POR_BIT) : 1;
   localparam logic [TW-1:0] FIM_MEIO = TW'(HALF_BIT - 1);
   localparam logic [TW-1:0] FIM_BIT  = TW'(CLOCKS_POR_BIT - 1);
   localparam logic [3:0]    ULTIMO   = 4'(N_AMOSTRAS - 1);

   logic [1:0]            sync_q;
   logic [TW-1:0]         timer_q, timer_d;
   logic [3:0]            bitcnt_q, bitcnt_d;
   logic [N_AMOSTRAS-1:0] shift_q, shift_d;
   logic [6:0]            dados_q, dados_d;
   logic                  erro_q, erro_d;
   logic                  rx_s;
   logic                  zera, conta, desloca, carrega;

   assign rx_s = sync_q[1];

   // Synchronizer idles high so reset never looks like a start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], dado_serial};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer_q  <= '0;
         bitcnt_q <= '0;
         shift_q  <= '0;
         dados_q  <= '0;
         erro_q   <= 1'b0;
      end else begin
         timer_q  <= timer_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         dados_q  <= dados_d;
         erro_q   <= erro_d;
      end
   end

   // Samples enter at the top, so after the last stop bit data sits LSB-aligned
   // with stop1/stop2 in the two upper positions.
   always_comb begin
      timer_d  = timer_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      dados_d  = dados_q;
      erro_d   = erro_q;
      if (zera) begin
         timer_d  = '0;
         bitcnt_d = '0;
      end else if (desloca) begin
         timer_d  = '0;
         bitcnt_d = bitcnt_q + 4'd1;
         shift_d  = {rx_s, shift_q[N_AMOSTRAS-1:1]};
      end else if (conta) begin
         timer_d  = timer_q + 1'b1;
      end
      if (carrega) begin
         dados_d = shift_q[N_DADOS-1:0];
         erro_d  = ~(&shift_q[N_AMOSTRAS-1:N_DADOS]);
      end
   end

   rx_serial_7n2_uc u_uc (
      .clock       (clock),
      .reset       (reset),
      .rx_s_i      (rx_s),
      .fim_meio_i  (timer_q == FIM_MEIO),
      .fim_bit_i   (timer_q == FIM_BIT),
      .ultimo_i    (bitcnt_q == ULTIMO),
      .zera_o      (zera),
      .conta_o     (conta),
      .desloca_o   (desloca),
      .carrega_o   (carrega),
      .tick_o      (db_tick),
      .pronto_o    (pronto),
      .db_estado_o (db_estado)
   );

   assign dados_ascii    = dados_q;
   assign erro_stop      = erro_q;
   assign db_clock       = clock;
   assign db_dado_serial = rx_s;

endmodule

// File: doc/rx_serial_7n2.md
Name: rx_serial_7n2

Overview:
Asynchronous serial receiver for 7N2 frames: 1 start bit, 7 data bits LSB first, no parity, 2 stop bits, 9600 baud from the 50 MHz system clock. It is the receiving end of the existing 7N2 transmitter and can be looped back to it on the board. It recovers the ASCII character, flags framing errors and exposes debug signals for the board displays.

Parameters:
CLOCKS_POR_BIT, 5208, system clocks per bit (50 MHz / 9600, truncated); benches may use a small value (e.g. 16).
HALF_BIT, CLOCKS_POR_BIT/2, delay from the start edge to the mid-start sample.

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
dado_serial  in  1  serial line, idle high
dados_ascii  out  7  last received character, registered
pronto  out  1  one-cycle pulse when a frame completes
erro_stop  out  1  framing error of the last frame; valid with pronto, held until the next pronto
db_clock  out  1  copy of clock
db_tick  out  1  one-cycle pulse at each bit sample point
db_dado_serial  out  1  synchronized serial line
db_estado  out  4  current FSM state code

Behaviour:
- Reset: asserting reset (low) forces all outputs to 0 and the FSM to INICIAL. This applies at any time, including mid-frame. The 2-FF synchronizer resets to 1 (idle line).
- dado_serial passes through a 2-FF synchronizer, giving rx_s. All decisions use rx_s. db_dado_serial = rx_s.
- FSM states and codes:
  - INICIAL (0): wait for rx_s = 0, then go to CONFIRMA and clear the bit counter/timer.
  - CONFIRMA (1): count HALF_BIT cycles, then sample rx_s. If rx_s = 1 (glitch/false start), return to INICIAL with no pronto. If 0, go to RECEBE.
  - RECEBE (2): sample every CLOCKS_POR_BIT cycles. 7 data samples are shifted in LSB first, then the stop1 and stop2 samples. After the stop2 sample, go to ARMAZENA.
  - ARMAZENA (3): load dados_ascii from the shift register. erro_stop = NOT(stop1 AND stop2).
  - FINAL (4): pronto = 1 for exactly this cycle. Next state is INICIAL if rx_s = 1, else ESPERA_IDLE.
  - ESPERA_IDLE (5): wait for rx_s = 1, then go to INICIAL. This prevents re-triggering on a line held low (break).
- Timing, with t0 = first cycle the FSM sees rx_s = 0 in INICIAL:
  - start sample at t0+HALF_BIT
  - data bit i (0..6) sampled at t0+HALF_BIT+(i+1)·CLOCKS_POR_BIT
  - stop1 sampled at +8·CLOCKS_POR_BIT, stop2 at +9·CLOCKS_POR_BIT
  - pronto at stop2 sample + 2 cycles
  - db_tick is high on every sample cycle, including the start sample.
- Back-to-back frames: INICIAL is re-entered about 3 cycles after the stop2 sample, well within the remaining half stop bit, so a start bit immediately after stop2 is never missed.
- dados_ascii changes only in ARMAZENA. It is updated even on a framing error; the data is then flagged by erro_stop.
- The shift register and counters are unused/don't-care outside CONFIRMA/RECEBE. The bit counter is 4 bits and the timer is wide enough for CLOCKS_POR_BIT-1.
- Unused db_estado codes (6–15) are never produced. An illegal state returns to INICIAL.

Decomposition:
- Shared package rx_serial_pkg:
  - state encodings (INICIAL…ESPERA_IDLE, 4-bit)
  - N_DADOS = 7, N_STOP = 2
  - default CLOCKS_POR_BIT = 5208
- One natural sub-module, rx_serial_7n2_uc: the control FSM, producing the count/shift/load/pronto controls and db_estado.
- Synchronizer, timer, bit counter and shift register stay in the top as datapath.

Test Plan:
- Reset, then frames 35h, 55h, 7Eh, 7Fh, each driven by the 7N2 transmitter in loopback (CLOCKS_POR_BIT=5208), 500 clocks between frames: each gives a pronto pulse of exactly 1 cycle with dados_ascii = 35h/55h/7Eh/7Fh and erro_stop = 0. Check pronto arrives HALF_BIT+9·CLOCKS_POR_BIT+2 cycles after t0.
- Glitch: dado_serial low for 1000 clocks then high: FSM returns to INICIAL from CONFIRMA, no pronto, dados_ascii unchanged.
- Framing error: send 2Ah with stop2 = 0: pronto pulses, dados_ascii = 2Ah, erro_stop = 1. FSM waits in ESPERA_IDLE until the line returns high, then a following 41h is received with erro_stop = 0.
- Break: line held low for 30 bit times: exactly one pronto with dados_ascii = 00h and erro_stop = 1, then FSM stays in ESPERA_IDLE (db_estado = 5) until the line goes high.
- Back-to-back: frames 55h then 2Ah with no idle gap between stop2 and the next start: two pronto pulses with 55h then 2Ah, no errors.
- Reset mid-frame: assert reset low during data bit 3 of 7Eh: all outputs go to 0 immediately. After release and an idle line, a new 35h is received correctly.
